// File: rtl/coeff_ram_loader.sv
// Run-time writable coefficient RAM for the FIR tap sequencer.
// It loads a valid/ready stream of coefficients and gives a one-cycle-latency read port.
module coeff_ram_loader #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_TAPS   = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  load_start_i,
  input  logic [DATA_WIDTH-1:0] s_data_i,
  input  logic                  s_valid_i,
  input  logic                  s_last_i,
  output logic                  s_ready_o,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o
);

  localparam int                DEPTH    = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] LAST_PTR = (ADDR_WIDTH+1)'(NUM_TAPS - 1);
  localparam logic [ADDR_WIDTH:0] PTR_ONE  = (ADDR_WIDTH+1)'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_DONE  = 2'd2,
    S_ERROR = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH:0]   r_wr_ptr;
  logic [ADDR_WIDTH:0]   w_wr_ptr_nxt;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_err;
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];
  logic                  w_beat;

  assign w_beat    = s_valid_i & r_busy;
  assign s_ready_o = r_busy;
  assign busy_o    = r_busy;
  assign done_o    = r_done;
  assign err_o     = r_err;
  assign rd_data_o = r_rd_data;

  // Next state and write pointer; early or missing last both end in ERROR
  always_comb begin
    w_state_nxt  = r_state;
    w_wr_ptr_nxt = r_wr_ptr;
    case (r_state)
      S_LOAD: begin
        if (w_beat) begin
          w_wr_ptr_nxt = r_wr_ptr + PTR_ONE;
          if (r_wr_ptr == LAST_PTR) begin
            w_state_nxt = s_last_i ? S_DONE : S_ERROR;
          end else if (s_last_i) begin
            w_state_nxt = S_ERROR;
          end else begin
            w_state_nxt = S_LOAD;
          end
        end else begin
          w_state_nxt = S_LOAD;
        end
      end
      S_IDLE, S_DONE, S_ERROR: begin
        if (load_start_i) begin
          w_state_nxt  = S_LOAD;
          w_wr_ptr_nxt = '0;
        end else begin
          w_state_nxt = r_state;
        end
      end
      default: begin
        w_state_nxt  = S_IDLE;
        w_wr_ptr_nxt = '0;
      end
    endcase
  end

  // State, pointer and status flags decoded from the next state so outputs come straight off flops
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= S_IDLE;
      r_wr_ptr <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_wr_ptr <= w_wr_ptr_nxt;
      r_busy   <= (w_state_nxt == S_LOAD);
      r_done   <= (w_state_nxt == S_DONE);
      r_err    <= (w_state_nxt == S_ERROR);
    end
  end

  // RAM write port; contents survive reset, but a beat in a reset cycle is dropped
  always_ff @(posedge clk_i) begin
    if (!rst_i && w_beat) begin
      r_mem[r_wr_ptr[ADDR_WIDTH-1:0]] <= s_data_i;
    end
  end

  // Read port, read-first against a same-cycle write
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rd_data <= '0;
    end else begin
      r_rd_data <= r_mem[rd_addr_i];
    end
  end

endmodule
